// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out receiver: frames serial bits into DATA_WIDTH words and
// presents them through a single-entry valid/ready holding register.
module deserializer_sipo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  srl_en,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  rx_active,
  output logic                  align_err,
  output logic                  overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    align_q, align_d;
  logic                    ovr_q, ovr_d;

  logic                    take_c;
  logic                    done_c;
  logic [CNT_W-1:0]        pos_c;
  logic [CNT_W-1:0]        idx_c;
  logic [DATA_WIDTH-1:0]   base_c;
  logic [DATA_WIDTH-1:0]   word_c;

  // State register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      align_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      align_q <= align_d;
      ovr_q   <= ovr_d;
    end
  end

  // Framing FSM, bit insertion and holding-register handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    align_d = 1'b0;
    ovr_d   = ovr_q;
    take_c  = 1'b0;
    done_c  = 1'b0;
    pos_c   = '0;
    base_c  = shift_q;

    if (srl_en) begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            take_c = 1'b1;
            base_c = '0;
            if (DATA_WIDTH == 1) begin
              done_c = 1'b1;
            end else begin
              state_d = SHIFT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        SHIFT: begin
          take_c = 1'b1;
          if (frame_start) begin
            base_c  = '0;
            align_d = 1'b1;
            cnt_d   = CNT_W'(1);
          end else begin
            pos_c = cnt_q;
            if (CNT_W'(cnt_q + 1'b1) == CNT_W'(DATA_WIDTH)) begin
              done_c  = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = CNT_W'(cnt_q + 1'b1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Line position to word bit index; mirrored for MSB-first links
    idx_c  = MSB_FIRST ? CNT_W'(CNT_W'(DATA_WIDTH - 1) - pos_c) : pos_c;
    word_c = base_c;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (CNT_W'(i) == idx_c) word_c[i] = srl_in;
    end
    if (take_c) shift_d = word_c;

    if (done_c) begin
      if (!valid_q || data_ready) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign rx_active  = (state_q == SHIFT);
  assign align_err  = align_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_deserializer_sipo.sv
// Bench for deserializer_sipo: hand-computed vector table, directed corner
// sequences and random traffic checked against a bit-queue reference model.
module tb_deserializer_sipo;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          srl_in = 1'b0;
  logic          srl_en = 1'b0;
  logic          frame_start = 1'b0;
  logic          data_ready = 1'b0;

  logic [DW-1:0] dout_l, dout_m;
  logic          valid_l, valid_m, act_l, act_m, aerr_l, aerr_m, ovr_l, ovr_m;

  always #5 clk = ~clk;

  deserializer_sipo #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .srl_in(srl_in), .srl_en(srl_en),
    .frame_start(frame_start), .data_out(dout_l), .data_valid(valid_l),
    .data_ready(data_ready), .rx_active(act_l), .align_err(aerr_l),
    .overrun(ovr_l)
  );

  deserializer_sipo #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .srl_in(srl_in), .srl_en(srl_en),
    .frame_start(frame_start), .data_out(dout_m), .data_valid(valid_m),
    .data_ready(data_ready), .rx_active(act_m), .align_err(aerr_m),
    .overrun(ovr_m)
  );

  int n_cmp = 0;
  int n_err = 0;
  int align_seen = 0;

  // Reference model: received bits kept as a queue, word assembled on completion
  logic          mq[$];
  logic          ev = 1'b0, eovr = 1'b0, ealign = 1'b0;
  logic [DW-1:0] edl = '0, edm = '0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic          done;
    logic [DW-1:0] wl, wm;
    done = 1'b0;
    wl = '0;
    wm = '0;
    if (rst) begin
      mq.delete();
      ev = 1'b0; eovr = 1'b0; ealign = 1'b0; edl = '0; edm = '0;
    end else begin
      ealign = 1'b0;
      if (srl_en) begin
        if (frame_start) begin
          ealign = (mq.size() != 0);
          mq.delete();
          mq.push_back(srl_in);
        end else if (mq.size() != 0) begin
          mq.push_back(srl_in);
        end
        if (mq.size() == DW) begin
          for (int i = 0; i < int'(DW); i++) begin
            wl[i]        = mq[i];
            wm[DW-1-i]   = mq[i];
          end
          done = 1'b1;
          mq.delete();
        end
      end
      if (done) begin
        if (!ev || data_ready) begin
          ev = 1'b1; edl = wl; edm = wm;
        end else begin
          eovr = 1'b1;
        end
      end else if (ev && data_ready) begin
        ev = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("data_lsb",   dout_l,  edl);
    chk("data_msb",   dout_m,  edm);
    chk("valid_lsb",  valid_l, ev);
    chk("valid_msb",  valid_m, ev);
    chk("active_lsb", act_l,   (mq.size() != 0));
    chk("active_msb", act_m,   (mq.size() != 0));
    chk("align_lsb",  aerr_l,  ealign);
    chk("align_msb",  aerr_m,  ealign);
    chk("ovr_lsb",    ovr_l,   eovr);
    chk("ovr_msb",    ovr_m,   eovr);
  endtask

  // One clock: drive inputs, advance the model, sample after the edge
  task automatic step(input logic r, input logic en, input logic fs,
                      input logic b, input logic rdy);
    rst = r; srl_en = en; frame_start = fs; srl_in = b; data_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    if (aerr_l) align_seen++;
    check_all();
  endtask

  task automatic send_word(input logic [DW-1:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < int'(DW); i++)
      step(1'b0, 1'b1, (i == 0), w[i], (i == int'(DW) - 1) ? rdy_last : rdy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic          r, en, fs, b, rdy;
    logic          ev, ea;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Basic LSB-first 0xA5 receive with hand-derived post-edge expectations
    tbl[0]  = '{r:1, en:0, fs:0, b:0, rdy:1, ev:0, ea:0, ed:8'h00};
    tbl[1]  = '{r:0, en:1, fs:1, b:1, rdy:1, ev:0, ea:1, ed:8'h00};
    tbl[2]  = '{r:0, en:1, fs:0, b:0, rdy:1, ev:0, ea:1, ed:8'h00};
    tbl[3]  = '{r:0, en:1, fs:0, b:1, rdy:1, ev:0, ea:1, ed:8'h00};
    tbl[4]  = '{r:0, en:1, fs:0, b:0, rdy:1, ev:0, ea:1, ed:8'h00};
    tbl[5]  = '{r:0, en:1, fs:0, b:0, rdy:1, ev:0, ea:1, ed:8'h00};
    tbl[6]  = '{r:0, en:1, fs:0, b:1, rdy:1, ev:0, ea:1, ed:8'h00};
    tbl[7]  = '{r:0, en:1, fs:0, b:0, rdy:1, ev:0, ea:1, ed:8'h00};
    tbl[8]  = '{r:0, en:1, fs:0, b:1, rdy:1, ev:1, ea:0, ed:8'hA5};
    tbl[9]  = '{r:0, en:0, fs:0, b:0, rdy:0, ev:1, ea:0, ed:8'hA5};
    tbl[10] = '{r:0, en:0, fs:0, b:0, rdy:1, ev:0, ea:0, ed:8'hA5};

    #2;
    // ea column holds the expected rx_active in this table
    for (int k = 0; k < 11; k++) begin
      step(tbl[k].r, tbl[k].en, tbl[k].fs, tbl[k].b, tbl[k].rdy);
      chk($sformatf("tbl%0d_valid", k),  valid_l, tbl[k].ev);
      chk($sformatf("tbl%0d_data", k),   dout_l,  tbl[k].ed);
      chk($sformatf("tbl%0d_active", k), act_l,   tbl[k].ea);
    end

    // Gaps mid-word and a consumer that stalls for 5 cycles
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i == 0), 8'h3C >> i, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 4; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h3C >> i, 1'b0);
    chk("gap_data", dout_l, 32'h3C);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", valid_l, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0, (i == 4));
    end
    chk("accept_clears", valid_l, 0);
    chk("data_kept", dout_l, 32'h3C);

    // Overrun when the holding register stays full
    do_reset();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    chk("ovr_data", dout_l, 32'h11);
    chk("ovr_flag", ovr_l, 1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_sticky", ovr_l, 1);

    // Same pair, but the consumer empties the register on the completion cycle
    do_reset();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1);
    chk("swap_data", dout_l, 32'h22);
    chk("swap_no_ovr", ovr_l, 0);

    // Early frame_start discards 3 bits
    do_reset();
    align_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, (i == 0), 1'b1, 1'b1);
    chk("early_no_word", valid_l, 0);
    send_word(8'hF0, 1'b0, 1'b0);
    chk("early_data", dout_l, 32'hF0);
    chk("align_pulses", align_seen, 1);

    // Reset mid-word, then unframed bits are ignored
    do_reset();
    send_word(8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, (i == 0), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_data", dout_l, 0);
    chk("rst_valid", valid_l, 0);
    chk("rst_active", act_l, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("unframed_idle", act_l, 0);
    send_word(8'h81, 1'b0, 1'b0);
    chk("post_rst_data", dout_l, 32'h81);

    // MSB-first instance on a symmetric pattern
    do_reset();
    send_word(8'hC3, 1'b1, 1'b1);
    chk("msb_data", dout_m, 32'hC3);
    chk("msb_valid", valid_m, 1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 12) == 0,
           1'($urandom), ($urandom % 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
